ifu_fetch: RTL and testbench
============================

IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 Parameter: RESET_PC, 64'h0000_0000_8000_0000, first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rstn  input  1  reset is asynchronous and active-low.
REQ-004 update  input  1  global pipeline-advance strobe; IF/ID register loads only when high.
REQ-005 redirect_en  input  1  taken branch/jump from execute stage; sampled only when update=1.
REQ-006 redirect_pc  input  64  redirect target.
REQ-007 imem_req  output  1  instruction-memory request valid.
REQ-008 imem_addr  output  64  request address, word aligned.
REQ-009 imem_ack  input  1  one-cycle response strobe; imem_rdata is valid in the same cycle.
REQ-010 imem_rdata  input  32  fetched instruction word.
REQ-011 ifu_instr  output  32  IF/ID instruction.
REQ-012 ifu_pc  output  64  IF/ID pc.
REQ-013 ifu_snxt_pc  output  64  IF/ID static next pc, pc+4.
REQ-014 ifu_valid  output  1  IF/ID slot holds a real instruction.
REQ-015 fetch_stall  output  1  high when no instruction is buffered; the pipeline controller withholds update while high.

Function
REQ-016 The block SHALL implement three states:
- FETCH: request outstanding.
- HOLD: instruction buffered.
- DROP: request outstanding whose response will be discarded.
REQ-017 The block SHALL hold registers fetch_pc (next address to fetch), req_addr (address on the bus), buf_instr and buf_pc.
REQ-018 The block SHALL assert imem_req=1 in FETCH and DROP and imem_req=0 in HOLD; imem_addr SHALL equal req_addr at all times.
REQ-019 While imem_req=1 and no imem_ack has arrived, req_addr SHALL remain stable, including across a redirect.
REQ-020 On entry to FETCH, req_addr SHALL be loaded from fetch_pc; the request SHALL be visible on the first cycle after entry.
REQ-021 FETCH with imem_ack and no redirect: the block SHALL capture buf_instr=imem_rdata and buf_pc=req_addr, then enter HOLD.
REQ-022 fetch_stall SHALL be 0 in HOLD and 1 in FETCH and DROP.
REQ-023 HOLD with update=1 and redirect_en=0, on one edge:
- ifu_instr<=buf_instr, ifu_pc<=buf_pc, ifu_snxt_pc<=buf_pc+4, ifu_valid<=1.
- fetch_pc<=buf_pc+4.
- state<=FETCH.
REQ-024 Adds SHALL be 64-bit modulo 2^64; 64'hFFFF_FFFF_FFFF_FFFC+4 SHALL wrap to 0.
REQ-025 update=1 in FETCH or DROP with redirect_en=0: ifu_valid<=0 (bubble), other ifu_* outputs hold.
REQ-026 update=1 with redirect_en=1 SHALL win over every other event:
- ifu_valid<=0.
- fetch_pc<={redirect_pc[63:2],2'b00}.
- The buffered instruction is discarded.
REQ-027 Next state on redirect:
- HOLD: FETCH.
- FETCH with imem_ack the same cycle: FETCH, discarding the data.
- FETCH without imem_ack: DROP.
- DROP: stays DROP, with the target overwritten by the newest redirect.
REQ-028 DROP with imem_ack: the response SHALL be discarded and the block SHALL enter FETCH at fetch_pc.
REQ-029 update=0: IF/ID outputs SHALL hold and redirect_en SHALL be ignored.
REQ-030 Latency: with imem_ack arriving N cycles after imem_req rises and update held at 1, instruction k SHALL appear on ifu_* exactly N+2 cycles after its request rises.

Reset
REQ-031 While rstn=0, regardless of clock:
- state=FETCH, fetch_pc=req_addr=RESET_PC.
- imem_req=0.
- ifu_valid=0, ifu_instr=0, ifu_pc=0, ifu_snxt_pc=0.
- buf_instr=0, buf_pc=0.
REQ-032 imem_req SHALL rise on the first clock edge after rstn deasserts, with imem_addr=RESET_PC.
REQ-033 Reset asserted mid-request SHALL abandon the transaction; any later imem_ack for it is ignored.

Verification
REQ-034 Reset release; ack 1 cycle after req with rdata=32'h00000513; update=1 -> ifu_instr=32'h00000513, ifu_pc=64'h8000_0000, ifu_snxt_pc=64'h8000_0004, ifu_valid=1; next imem_addr=64'h8000_0004.
REQ-035 Ack delayed 5 cycles, update=1 throughout -> ifu_valid=0 on every edge until data arrives; imem_addr stable at 64'h8000_0000 for all 6 request cycles.
REQ-036 HOLD at pc 64'h8000_0008; update=1, redirect_en=1, redirect_pc=64'h8000_0102 -> ifu_valid=0; next imem_addr=64'h8000_0100.
REQ-037 Redirect to 64'h8000_0200 while request to 64'h8000_0010 is outstanding -> addr stays 64'h8000_0010 until ack; data discarded; next request 64'h8000_0200; ifu_valid never 1 for 64'h8000_0010.
REQ-038 RESET_PC=64'hFFFF_FFFF_FFFF_FFFC -> ifu_snxt_pc=0; second fetch address=0.
REQ-039 rstn pulsed low mid-request, stale ack 1 cycle after release -> ignored; fresh request at RESET_PC; first valid instruction comes from the new ack.

Source files
------------

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one outstanding imem request, a one-entry instruction
// buffer and the IF/ID pipeline register, with redirect and in-flight drop handling.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   FETCH | request outstanding (or about to be issued right after reset)
//   HOLD  | instruction buffered, waiting for update to move it into IF/ID
//   DROP  | request outstanding whose response is stale and will be thrown away
module ifu_fetch #(
   parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        update,
   input  logic        redirect_en,
   input  logic [63:0] redirect_pc,
   output logic        imem_req,
   output logic [63:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] ifu_instr,
   output logic [63:0] ifu_pc,
   output logic [63:0] ifu_snxt_pc,
   output logic        ifu_valid,
   output logic        fetch_stall
);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      DROP  = 2'd2
   } state_t;

   state_t      state, state_nxt;
   logic [63:0] fetch_pc, fetch_pc_nxt;
   logic [63:0] req_addr, req_addr_nxt;
   logic        req_vld, req_vld_nxt;
   logic [31:0] buf_instr, buf_instr_nxt;
   logic [63:0] buf_pc, buf_pc_nxt;
   logic [31:0] ifu_instr_nxt;
   logic [63:0] ifu_pc_nxt, ifu_snxt_pc_nxt;
   logic        ifu_valid_nxt;

   logic        ack_vld;
   logic        redir;
   logic [63:0] redir_tgt;
   logic [63:0] buf_snxt;

   // req_vld is low for the first cycle after reset, so an ack left over from
   // a transaction abandoned by reset can never be mistaken for a response.
   assign imem_req    = req_vld;
   assign imem_addr   = req_addr;
   assign fetch_stall = (state != HOLD);

   assign ack_vld   = req_vld & imem_ack;
   assign redir     = update & redirect_en;
   assign redir_tgt = redirect_pc & ~64'd3;
   assign buf_snxt  = buf_pc + 64'd4;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= FETCH;
         fetch_pc    <= RESET_PC;
         req_addr    <= RESET_PC;
         req_vld     <= 1'b0;
         buf_instr   <= '0;
         buf_pc      <= '0;
         ifu_instr   <= '0;
         ifu_pc      <= '0;
         ifu_snxt_pc <= '0;
         ifu_valid   <= 1'b0;
      end else begin
         state       <= state_nxt;
         fetch_pc    <= fetch_pc_nxt;
         req_addr    <= req_addr_nxt;
         req_vld     <= req_vld_nxt;
         buf_instr   <= buf_instr_nxt;
         buf_pc      <= buf_pc_nxt;
         ifu_instr   <= ifu_instr_nxt;
         ifu_pc      <= ifu_pc_nxt;
         ifu_snxt_pc <= ifu_snxt_pc_nxt;
         ifu_valid   <= ifu_valid_nxt;
      end
   end

   always_comb begin
      state_nxt       = state;
      fetch_pc_nxt    = fetch_pc;
      req_addr_nxt    = req_addr;
      req_vld_nxt     = req_vld;
      buf_instr_nxt   = buf_instr;
      buf_pc_nxt      = buf_pc;
      ifu_instr_nxt   = ifu_instr;
      ifu_pc_nxt      = ifu_pc;
      ifu_snxt_pc_nxt = ifu_snxt_pc;
      ifu_valid_nxt   = ifu_valid;

      case (state)
         FETCH: begin
            if (update)
               ifu_valid_nxt = 1'b0;
            if (redir) begin
               fetch_pc_nxt = redir_tgt;
               if (ack_vld || !req_vld) begin
                  // nothing in flight any more: issue the target immediately
                  req_addr_nxt = redir_tgt;
                  req_vld_nxt  = 1'b1;
               end else begin
                  state_nxt = DROP;
               end
            end else if (ack_vld) begin
               buf_instr_nxt = imem_rdata;
               buf_pc_nxt    = req_addr;
               req_vld_nxt   = 1'b0;
               state_nxt     = HOLD;
            end else begin
               req_vld_nxt = 1'b1;
            end
         end

         HOLD: begin
            if (redir) begin
               ifu_valid_nxt = 1'b0;
               fetch_pc_nxt  = redir_tgt;
               req_addr_nxt  = redir_tgt;
               req_vld_nxt   = 1'b1;
               state_nxt     = FETCH;
            end else if (update) begin
               ifu_instr_nxt   = buf_instr;
               ifu_pc_nxt      = buf_pc;
               ifu_snxt_pc_nxt = buf_snxt;
               ifu_valid_nxt   = 1'b1;
               fetch_pc_nxt    = buf_snxt;
               req_addr_nxt    = buf_snxt;
               req_vld_nxt     = 1'b1;
               state_nxt       = FETCH;
            end
         end

         DROP: begin
            if (update)
               ifu_valid_nxt = 1'b0;
            if (redir)
               fetch_pc_nxt = redir_tgt;
            if (ack_vld) begin
               req_addr_nxt = redir ? redir_tgt : fetch_pc;
               req_vld_nxt  = 1'b1;
               state_nxt    = FETCH;
            end
         end

         default: begin
            state_nxt = FETCH;
         end
      endcase
   end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: a vector table walked cycle by cycle, plus
// hand-written reset-abandon and address-wrap sequences.
module tb_ifu_fetch;

   localparam logic [63:0] B = 64'h0000_0000_8000_0000;
   localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        update = 1'b0;
   logic        redirect_en = 1'b0;
   logic [63:0] redirect_pc = '0;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic [31:0] ifu_instr;
   logic [63:0] ifu_pc, ifu_snxt_pc;
   logic        ifu_valid, fetch_stall;

   logic        w_rstn = 1'b0;
   logic        w_update = 1'b0;
   logic        w_imem_req;
   logic [63:0] w_imem_addr;
   logic        w_imem_ack = 1'b0;
   logic [31:0] w_imem_rdata = '0;
   logic [31:0] w_ifu_instr;
   logic [63:0] w_ifu_pc, w_ifu_snxt_pc;
   logic        w_ifu_valid, w_fetch_stall;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   ifu_fetch dut (
      .clk(clk), .rstn(rstn), .update(update), .redirect_en(redirect_en),
      .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .ifu_instr(ifu_instr),
      .ifu_pc(ifu_pc), .ifu_snxt_pc(ifu_snxt_pc), .ifu_valid(ifu_valid),
      .fetch_stall(fetch_stall)
   );

   ifu_fetch #(.RESET_PC(WRAP_PC)) dut_w (
      .clk(clk), .rstn(w_rstn), .update(w_update), .redirect_en(1'b0),
      .redirect_pc(64'd0), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
      .imem_ack(w_imem_ack), .imem_rdata(w_imem_rdata), .ifu_instr(w_ifu_instr),
      .ifu_pc(w_ifu_pc), .ifu_snxt_pc(w_ifu_snxt_pc), .ifu_valid(w_ifu_valid),
      .fetch_stall(w_fetch_stall)
   );

   typedef struct {
      bit          rst;
      bit          upd;
      bit          red;
      logic [63:0] rpc;
      bit          ack;
      logic [31:0] rdata;
      bit          e_req;
      logic [63:0] e_addr;
      bit          e_valid;
      logic [31:0] e_instr;
      logic [63:0] e_pc;
      bit          e_stall;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(bit rst, bit upd, bit red, logic [63:0] rpc, bit ack,
                               logic [31:0] rdata, bit e_req, logic [63:0] e_addr,
                               bit e_valid, logic [31:0] e_instr, logic [63:0] e_pc,
                               bit e_stall);
      vec_t v;
      v.rst = rst; v.upd = upd; v.red = red; v.rpc = rpc; v.ack = ack; v.rdata = rdata;
      v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_instr = e_instr;
      v.e_pc = e_pc; v.e_stall = e_stall;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_outputs(input string tag, input bit e_req, input logic [63:0] e_addr,
                              input bit e_valid, input logic [31:0] e_instr,
                              input logic [63:0] e_pc, input logic [63:0] e_snxt,
                              input bit e_stall);
      chk({tag, ".imem_req"},    64'(imem_req),    64'(e_req));
      chk({tag, ".imem_addr"},   imem_addr,        e_addr);
      chk({tag, ".ifu_valid"},   64'(ifu_valid),   64'(e_valid));
      chk({tag, ".ifu_instr"},   64'(ifu_instr),   64'(e_instr));
      chk({tag, ".ifu_pc"},      ifu_pc,           e_pc);
      chk({tag, ".ifu_snxt_pc"}, ifu_snxt_pc,      e_snxt);
      chk({tag, ".fetch_stall"}, 64'(fetch_stall), 64'(e_stall));
   endtask

   task automatic drive(input bit upd, input bit red, input logic [63:0] rpc,
                        input bit ack, input logic [31:0] rdata);
      update = upd; redirect_en = red; redirect_pc = rpc;
      imem_ack = ack; imem_rdata = rdata;
   endtask

   initial begin
      // ack 5 cycles late, then HOLD/update=0/redirect-ignored, HOLD redirect,
      // FETCH redirect to DROP with an overwriting second redirect, ack+redirect.
      tbl.push_back(mk(1,1,0,0,0,0,                 0,B,0,0,0,1));
      tbl.push_back(mk(0,1,0,0,0,0,                 1,B,0,0,0,1));
      tbl.push_back(mk(0,1,0,0,0,0,                 1,B,0,0,0,1));
      tbl.push_back(mk(0,1,0,0,0,0,                 1,B,0,0,0,1));
      tbl.push_back(mk(0,1,0,0,0,0,                 1,B,0,0,0,1));
      tbl.push_back(mk(0,1,0,0,0,0,                 1,B,0,0,0,1));
      tbl.push_back(mk(0,1,0,0,1,32'h00100093,      1,B,0,0,0,1));
      tbl.push_back(mk(0,1,0,0,0,0,                 0,B,0,0,0,0));
      tbl.push_back(mk(0,0,0,0,1,32'h00200113,      1,B+4,1,32'h00100093,B,1));
      tbl.push_back(mk(0,0,1,64'h1234,0,0,          0,B+4,1,32'h00100093,B,0));
      tbl.push_back(mk(0,1,0,0,0,0,                 0,B+4,1,32'h00100093,B,0));
      tbl.push_back(mk(0,1,0,0,1,32'h00300193,      1,B+8,1,32'h00200113,B+4,1));
      tbl.push_back(mk(0,1,1,B+'h102,0,0,           0,B+8,0,32'h00200113,B+4,0));
      tbl.push_back(mk(0,1,0,0,1,32'h00400213,      1,B+'h100,0,32'h00200113,B+4,1));
      tbl.push_back(mk(0,1,0,0,0,0,                 0,B+'h100,0,32'h00200113,B+4,0));
      tbl.push_back(mk(0,1,1,B+'h200,0,0,           1,B+'h104,1,32'h00400213,B+'h100,1));
      tbl.push_back(mk(0,1,1,B+'h303,0,0,           1,B+'h104,0,32'h00400213,B+'h100,1));
      tbl.push_back(mk(0,1,0,0,1,32'hDEADBEEF,      1,B+'h104,0,32'h00400213,B+'h100,1));
      tbl.push_back(mk(0,1,0,0,1,32'h00500293,      1,B+'h300,0,32'h00400213,B+'h100,1));
      tbl.push_back(mk(0,1,0,0,0,0,                 0,B+'h300,0,32'h00400213,B+'h100,0));
      tbl.push_back(mk(0,1,1,B+'h400,1,32'hBAD0BAD0,1,B+'h304,1,32'h00500293,B+'h300,1));
      tbl.push_back(mk(0,1,0,0,1,32'h00600313,      1,B+'h400,0,32'h00500293,B+'h300,1));
      tbl.push_back(mk(0,1,0,0,0,0,                 0,B+'h400,0,32'h00500293,B+'h300,0));
      tbl.push_back(mk(0,1,0,0,0,0,                 1,B+'h404,1,32'h00600313,B+'h400,1));
      // fresh reset: ack one cycle after req, then redirect while B+0x10 is in flight
      tbl.push_back(mk(1,1,0,0,0,0,                 0,B,0,0,0,1));
      tbl.push_back(mk(0,1,0,0,0,0,                 1,B,0,0,0,1));
      tbl.push_back(mk(0,1,0,0,1,32'h00000513,      1,B,0,0,0,1));
      tbl.push_back(mk(0,1,0,0,0,0,                 0,B,0,0,0,0));
      tbl.push_back(mk(0,1,0,0,1,32'h00700393,      1,B+4,1,32'h00000513,B,1));
      tbl.push_back(mk(0,1,0,0,0,0,                 0,B+4,0,32'h00000513,B,0));
      tbl.push_back(mk(0,1,0,0,1,32'h00800413,      1,B+8,1,32'h00700393,B+4,1));
      tbl.push_back(mk(0,1,0,0,0,0,                 0,B+8,0,32'h00700393,B+4,0));
      tbl.push_back(mk(0,1,0,0,1,32'h00900493,      1,B+'hC,1,32'h00800413,B+8,1));
      tbl.push_back(mk(0,1,0,0,0,0,                 0,B+'hC,0,32'h00800413,B+8,0));
      tbl.push_back(mk(0,1,1,B+'h200,0,0,           1,B+'h10,1,32'h00900493,B+'hC,1));
      tbl.push_back(mk(0,1,0,0,0,0,                 1,B+'h10,0,32'h00900493,B+'hC,1));
      tbl.push_back(mk(0,1,0,0,1,32'h0BADC0DE,      1,B+'h10,0,32'h00900493,B+'hC,1));
      tbl.push_back(mk(0,1,0,0,1,32'h00A00513,      1,B+'h200,0,32'h00900493,B+'hC,1));
      tbl.push_back(mk(0,1,0,0,0,0,                 0,B+'h200,0,32'h00900493,B+'hC,0));
      tbl.push_back(mk(0,0,0,0,0,0,                 1,B+'h204,1,32'h00A00513,B+'h200,1));

      @(negedge clk);
      foreach (tbl[i]) begin
         if (tbl[i].rst) begin
            rstn = 1'b0;
            drive(0, 0, '0, 0, '0);
            #1;
            chk_outputs($sformatf("rst%0d", i), 0, B, 0, '0, '0, '0, 1);
            @(negedge clk);
            rstn = 1'b1;
         end
         chk_outputs($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_valid,
                     tbl[i].e_instr, tbl[i].e_pc,
                     (tbl[i].e_pc == '0) ? 64'd0 : tbl[i].e_pc + 64'd4, tbl[i].e_stall);
         drive(tbl[i].upd, tbl[i].red, tbl[i].rpc, tbl[i].ack, tbl[i].rdata);
         @(negedge clk);
      end

      // reset mid-request; stale ack in the first cycle after release is ignored
      rstn = 1'b0;
      drive(0, 0, '0, 0, '0);
      #1;
      chk("midrst.imem_req", 64'(imem_req), 64'd0);
      chk("midrst.ifu_valid", 64'(ifu_valid), 64'd0);
      @(negedge clk);
      rstn = 1'b1;
      drive(1, 0, '0, 1, 32'hFFFF_FFFF);
      @(negedge clk);
      drive(1, 0, '0, 0, '0);
      chk_outputs("stale", 1, B, 0, '0, '0, '0, 1);
      @(negedge clk);
      drive(1, 0, '0, 1, 32'h00B00593);
      chk("fresh.imem_addr", imem_addr, B);
      @(negedge clk);
      drive(1, 0, '0, 0, '0);
      chk("fresh.fetch_stall", 64'(fetch_stall), 64'd0);
      @(negedge clk);
      chk_outputs("fresh", 1, B+4, 1, 32'h00B00593, B, B+4, 1);

      // top-of-address-space reset pc: pc+4 wraps to zero
      w_rstn = 1'b1;
      @(negedge clk);
      chk("wrap.imem_req", 64'(w_imem_req), 64'd1);
      chk("wrap.imem_addr0", w_imem_addr, WRAP_PC);
      w_imem_ack = 1'b1; w_imem_rdata = 32'h0000_0013; w_update = 1'b1;
      @(negedge clk);
      w_imem_ack = 1'b0;
      chk("wrap.fetch_stall", 64'(w_fetch_stall), 64'd0);
      @(negedge clk);
      chk("wrap.ifu_valid", 64'(w_ifu_valid), 64'd1);
      chk("wrap.ifu_pc", w_ifu_pc, WRAP_PC);
      chk("wrap.ifu_snxt_pc", w_ifu_snxt_pc, 64'd0);
      chk("wrap.imem_addr1", w_imem_addr, 64'd0);
      chk("wrap.imem_req1", 64'(w_imem_req), 64'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
